encoder8to3_seq: RTL and testbench
==================================

# encoder8to3_seq

Sequential 8-to-3 encoder: captures an 8-bit request vector on a load strobe, then emits the 3-bit index of every set bit, one per handshake, in fixed priority order. It is the encoding counterpart of the team's 3-to-8 decoder: decoder output lines feed back here as event/request flags and are serialised into indices on a valid/ready stream.

## Interface
- PRIO_HIGH, default 0: 0 = lowest set index emitted first; 1 = highest set index first.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  8  request vector; sampled only on an accepted load.
- en  input  1  load strobe.
- dout  output  3  encoded index of the current request bit.
- valid  output  1  dout holds a code.
- ready  input  1  consumer accepts dout when valid=1.
- remaining  output  4  number of set bits still pending, including the one on dout (0..8).
- drop  output  1  one-cycle pulse: a load was refused because the block was busy.

## Operation
- Internal state: pending[7:0] (bits not yet emitted). Two states, IDLE (valid=0) and EMIT (valid=1). All outputs are registered.
- Reset (rst_n=0, any time): pending=0, dout=0, valid=0, remaining=0, drop=0; state IDLE. Takes effect immediately, not at the next clock edge. Any drain in progress is discarded.
- IDLE, en=1, din!=0: load accepted. pending<=din, dout<=priority index of din, remaining<=popcount(din), valid<=1; go to EMIT.
- IDLE, en=1, din=0: ignored. No state change, drop stays 0.
- EMIT, en=1: load refused. drop=1 for exactly one cycle; pending, dout, valid and remaining are unaffected.
- EMIT, valid=1 and ready=1 (handshake): nxt = pending with bit dout cleared. Then pending<=nxt, remaining<=remaining-1.
  - If nxt!=0: dout<=priority index of nxt and valid stays 1.
  - If nxt=0: valid<=0, dout<=0, and return to IDLE.
- EMIT, ready=0: dout, valid, pending and remaining hold. The output is stable under backpressure.
- Priority index:
  - PRIO_HIGH=0: position of the least-significant 1.
  - PRIO_HIGH=1: position of the most-significant 1.
- Invariants:
  - Each set bit of a loaded vector is emitted exactly once, in strict priority order.
  - remaining = popcount(pending) at all times.
  - valid = (pending!=0).
- Simultaneous final handshake and en in the same cycle: the block is still busy that cycle, so the load is refused and drop pulses. A load is accepted only in a cycle where valid=0.

## Timing
- Load latency: en accepted at rising edge k; valid=1 and the first code are visible after edge k.
- Throughput: one code per cycle while ready=1. A vector with N set bits drains in N cycles.
- IDLE again: valid falls after the edge of the last handshake. The earliest next accepted load is at the following edge, i.e. N+1 edges between accepted loads.
- drop is asserted after the edge that samples the refused en, and clears after the next edge unless en is refused again.
- Outputs never change without a clock edge, except on reset assertion.

## Test plan
- Reset: hold rst_n=0 with en=1, din=8'hFF -> dout=0, valid=0, remaining=0, drop=0. Release reset, then drive en=0 -> outputs stay 0.
- Drain, PRIO_HIGH=0: load din=8'b1010_0100, ready held 1 -> dout 2,5,7 on three consecutive cycles, remaining 3,2,1; valid=0 and remaining=0 on the 4th cycle.
- Backpressure: load 8'h81, ready=0 for 3 cycles -> dout=0, valid=1, remaining=2 held steady. Then ready=1 -> dout 0 then 7, then valid=0.
- PRIO_HIGH=1: load 8'h81 -> dout 7 then 0. Load 8'h10 -> single code 4, remaining=1, then valid=0.
- Refused/ignored loads:
  - en=1, din=8'h0F during an active drain -> single-cycle drop=1; the original code sequence is unchanged.
  - en with din=0 in IDLE -> no valid, no drop.
  - en in the same cycle as the final handshake -> drop=1 and no new load.
- Reset mid-drain: load 8'hFF, after 3 handshakes pulse rst_n low between clock edges -> outputs clear immediately. The next load of 8'h02 yields only dout=1.

Source files
------------

// File: rtl/encoder8to3_seq_if.sv
// Request/stream bundle for encoder8to3_seq: load side (din/en/drop) and
// the index stream (dout/valid/ready/remaining).
interface encoder8to3_seq_if;
   logic [7:0] din;
   logic       en;
   logic [2:0] dout;
   logic       valid;
   logic       ready;
   logic [3:0] remaining;
   logic       drop;

   // master: the encoder, which produces the index stream
   modport master (
      input  din,
      input  en,
      input  ready,
      output dout,
      output valid,
      output remaining,
      output drop
   );

   // slave: whoever loads vectors and consumes the indices
   modport slave (
      output din,
      output en,
      output ready,
      input  dout,
      input  valid,
      input  remaining,
      input  drop
   );
endinterface

// File: rtl/encoder8to3_seq.sv
// Sequential 8-to-3 encoder: latches a request vector and serialises the index
// of every set bit, one per valid/ready handshake, in fixed priority order.
module encoder8to3_seq #(
   parameter bit PRIO_HIGH = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   encoder8to3_seq_if.master    bus,
   output logic                 dbg_state
);

   // Stream handshake: a code transfers on a rising edge where valid=1 and
   // ready=1; while valid=1 and ready=0, dout/remaining are held unchanged.

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0] state;
   logic [7:0] pending;
   logic [7:0] nxt;
   logic [2:0] dout_q;
   logic [3:0] remaining_q;
   logic       drop_q;

   function automatic logic [2:0] prio_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      if (PRIO_HIGH) begin
         for (int i = 0; i < 8; i++)
            if (v[i]) idx = 3'(i);
      end else begin
         for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++)
         c = c + {3'b000, v[i]};
      return c;
   endfunction

   // Pending set after retiring the code currently on dout
   always_comb begin
      nxt = pending & ~(8'h01 << dout_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= 8'h00;
         dout_q      <= 3'd0;
         remaining_q <= 4'd0;
         drop_q      <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en && (bus.din != 8'h00)) begin
                  pending     <= bus.din;
                  dout_q      <= prio_idx(bus.din);
                  remaining_q <= popcount(bus.din);
                  state       <= EMIT;
               end
            end
            EMIT: begin
               // Busy for the whole drain, including the final handshake cycle
               if (bus.en) drop_q <= 1'b1;
               if (bus.ready) begin
                  pending     <= nxt;
                  remaining_q <= remaining_q - 4'd1;
                  if (nxt != 8'h00) begin
                     dout_q <= prio_idx(nxt);
                  end else begin
                     dout_q <= 3'd0;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dout      = dout_q;
   assign bus.valid     = (state == EMIT);
   assign bus.remaining = remaining_q;
   assign bus.drop      = drop_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Directed bench for encoder8to3_seq: one instance per priority order, both
// driven with the same vectors and checked against hand-computed sequences.
module tb_encoder8to3_seq;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       en;
   logic       ready;
   logic       dbg_lo;
   logic       dbg_hi;

   int checks = 0;
   int errors = 0;

   encoder8to3_seq_if bus_lo ();
   encoder8to3_seq_if bus_hi ();

   assign bus_lo.din   = din;
   assign bus_lo.en    = en;
   assign bus_lo.ready = ready;
   assign bus_hi.din   = din;
   assign bus_hi.en    = en;
   assign bus_hi.ready = ready;

   encoder8to3_seq #(.PRIO_HIGH(1'b0)) u_lo (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_lo.master),
      .dbg_state (dbg_lo)
   );

   encoder8to3_seq #(.PRIO_HIGH(1'b1)) u_hi (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_hi.master),
      .dbg_state (dbg_hi)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full output set of one instance
   task automatic check_lo(input string tag, input logic [2:0] d, input logic v,
                           input logic [3:0] r, input logic dr);
      check({tag, ".lo.dout"},      {5'd0, bus_lo.dout},      {5'd0, d});
      check({tag, ".lo.valid"},     {7'd0, bus_lo.valid},     {7'd0, v});
      check({tag, ".lo.remaining"}, {4'd0, bus_lo.remaining}, {4'd0, r});
      check({tag, ".lo.drop"},      {7'd0, bus_lo.drop},      {7'd0, dr});
      check({tag, ".lo.state"},     {7'd0, dbg_lo},           {7'd0, v});
   endtask

   task automatic check_hi(input string tag, input logic [2:0] d, input logic v,
                           input logic [3:0] r, input logic dr);
      check({tag, ".hi.dout"},      {5'd0, bus_hi.dout},      {5'd0, d});
      check({tag, ".hi.valid"},     {7'd0, bus_hi.valid},     {7'd0, v});
      check({tag, ".hi.remaining"}, {4'd0, bus_hi.remaining}, {4'd0, r});
      check({tag, ".hi.drop"},      {7'd0, bus_hi.drop},      {7'd0, dr});
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      din   = 8'hFF;
      ready = 1'b1;

      // reset holds outputs at zero even with a load requested
      tick();
      tick();
      check_lo("rst", 3'd0, 1'b0, 4'd0, 1'b0);
      check_hi("rst", 3'd0, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b1;
      en    = 1'b0;
      tick();
      check_lo("post_rst", 3'd0, 1'b0, 4'd0, 1'b0);

      // drain A4 with ready held high: lo 2,5,7  hi 7,5,2
      din = 8'hA4; en = 1'b1;
      tick();
      en = 1'b0;
      check_lo("drain0", 3'd2, 1'b1, 4'd3, 1'b0);
      check_hi("drain0", 3'd7, 1'b1, 4'd3, 1'b0);
      tick();
      check_lo("drain1", 3'd5, 1'b1, 4'd2, 1'b0);
      check_hi("drain1", 3'd5, 1'b1, 4'd2, 1'b0);
      tick();
      check_lo("drain2", 3'd7, 1'b1, 4'd1, 1'b0);
      check_hi("drain2", 3'd2, 1'b1, 4'd1, 1'b0);
      tick();
      check_lo("drain3", 3'd0, 1'b0, 4'd0, 1'b0);
      check_hi("drain3", 3'd0, 1'b0, 4'd0, 1'b0);

      // backpressure on 81
      ready = 1'b0; din = 8'h81; en = 1'b1;
      tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_lo("bp_hold", 3'd0, 1'b1, 4'd2, 1'b0);
         check_hi("bp_hold", 3'd7, 1'b1, 4'd2, 1'b0);
         tick();
      end
      check_lo("bp_hold3", 3'd0, 1'b1, 4'd2, 1'b0);
      ready = 1'b1;
      tick();
      check_lo("bp_rel0", 3'd7, 1'b1, 4'd1, 1'b0);
      check_hi("bp_rel0", 3'd0, 1'b1, 4'd1, 1'b0);
      tick();
      check_lo("bp_rel1", 3'd0, 1'b0, 4'd0, 1'b0);

      // single-bit vector 10
      din = 8'h10; en = 1'b1;
      tick();
      en = 1'b0;
      check_lo("single0", 3'd4, 1'b1, 4'd1, 1'b0);
      check_hi("single0", 3'd4, 1'b1, 4'd1, 1'b0);
      tick();
      check_hi("single1", 3'd0, 1'b0, 4'd0, 1'b0);

      // refused load mid-drain leaves the sequence untouched
      din = 8'hA4; en = 1'b1;
      tick();
      check_lo("refuse0", 3'd2, 1'b1, 4'd3, 1'b0);
      din = 8'h0F;
      tick();
      en = 1'b0;
      check_lo("refuse1", 3'd5, 1'b1, 4'd2, 1'b1);
      check_hi("refuse1", 3'd5, 1'b1, 4'd2, 1'b1);
      tick();
      check_lo("refuse2", 3'd7, 1'b1, 4'd1, 1'b0);
      tick();
      check_lo("refuse3", 3'd0, 1'b0, 4'd0, 1'b0);

      // zero vector in IDLE is ignored
      din = 8'h00; en = 1'b1;
      tick();
      en = 1'b0;
      check_lo("zero_load", 3'd0, 1'b0, 4'd0, 1'b0);

      // load during final handshake is refused
      din = 8'h01; en = 1'b1;
      tick();
      check_lo("final0", 3'd0, 1'b1, 4'd1, 1'b0);
      din = 8'h0F;
      tick();
      en = 1'b0;
      check_lo("final1", 3'd0, 1'b0, 4'd0, 1'b1);
      check_hi("final1", 3'd0, 1'b0, 4'd0, 1'b1);
      tick();
      check_lo("final2", 3'd0, 1'b0, 4'd0, 1'b0);

      // asynchronous reset mid-drain of FF
      din = 8'hFF; en = 1'b1;
      tick();
      en = 1'b0;
      check_lo("ff0", 3'd0, 1'b1, 4'd8, 1'b0);
      check_hi("ff0", 3'd7, 1'b1, 4'd8, 1'b0);
      tick();
      tick();
      tick();
      check_lo("ff3", 3'd3, 1'b1, 4'd5, 1'b0);
      check_hi("ff3", 3'd4, 1'b1, 4'd5, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_lo("async_rst", 3'd0, 1'b0, 4'd0, 1'b0);
      check_hi("async_rst", 3'd0, 1'b0, 4'd0, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();
      check_lo("after_rst", 3'd0, 1'b0, 4'd0, 1'b0);
      din = 8'h02; en = 1'b1;
      tick();
      en = 1'b0;
      check_lo("reload0", 3'd1, 1'b1, 4'd1, 1'b0);
      check_hi("reload0", 3'd1, 1'b1, 4'd1, 1'b0);
      tick();
      check_lo("reload1", 3'd0, 1'b0, 4'd0, 1'b0);
      check_hi("reload1", 3'd0, 1'b0, 4'd0, 1'b0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
